// File: rtl/stack_engine_pkg.sv
// Shared definitions for the stack engine: op encodings, FSM state
// encodings and the default datapath geometry.
package stack_engine_pkg;

  localparam int DEF_WIDTH = 16;
  localparam int DEF_DEPTH = 16;

  typedef enum logic [2:0] {
    OP_NOP     = 3'd0,
    OP_PUSH    = 3'd1,
    OP_POP     = 3'd2,
    OP_DUP     = 3'd3,
    OP_SWAP    = 3'd4,
    OP_REPLACE = 3'd5,
    OP_CLEAR   = 3'd6,
    OP_NOP7    = 3'd7
  } op_e;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SWAP2 = 1'b1
  } state_e;

endpackage

// File: rtl/stack_ram.sv
// Stack storage: DEPTH x WIDTH register array, not reset.
// Ports:
//   clk       - rising-edge clock
//   wr_en     - write strobe for the single synchronous write port
//   wr_addr   - write index
//   wr_data   - write data
//   rd_addr_a - asynchronous read index (top of stack)
//   rd_data_a - asynchronous read data
//   rd_addr_b - asynchronous read index (one below top)
//   rd_data_b - asynchronous read data
module stack_ram #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 16,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic [AW-1:0]    rd_addr_a,
  output logic [WIDTH-1:0] rd_data_a,
  input  logic [AW-1:0]    rd_addr_b,
  output logic [WIDTH-1:0] rd_data_b
);

  logic [WIDTH-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wr_addr] <= wr_data;
    end
  end

  assign rd_data_a = mem_q[rd_addr_a];
  assign rd_data_b = mem_q[rd_addr_b];

endmodule

// File: rtl/stack_engine.sv
// Parametrised operand/return stack with PUSH/POP/DUP/SWAP/REPLACE/CLEAR,
// full/empty status, sticky overflow/underflow flags and a valid/ready
// op handshake. SWAP takes two cycles; everything else takes one.
// Ports:
//   clk       - rising-edge clock
//   reset     - asynchronous active-low reset
//   op_valid  - op request strobe
//   op        - op code (see stack_engine_pkg::op_e)
//   op_ready  - high when an op can be accepted this cycle
//   din       - data for PUSH/REPLACE
//   dout      - registered top-of-stack (0 when empty)
//   count     - occupancy 0..DEPTH
//   empty     - count == 0
//   full      - count == DEPTH
//   overflow  - sticky: push-type op attempted while full
//   underflow - sticky: pop-type op attempted with too few entries
//   err_clr   - clears both sticky flags (a same-cycle error wins)
module stack_engine
  import stack_engine_pkg::*;
#(
  parameter  int WIDTH = DEF_WIDTH,
  parameter  int DEPTH = DEF_DEPTH,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             op_valid,
  input  logic [2:0]       op,
  output logic             op_ready,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic [AW:0]      count,
  output logic             empty,
  output logic             full,
  output logic             overflow,
  output logic             underflow,
  input  logic             err_clr
);

  localparam logic [AW:0] CNT_FULL = (AW+1)'(DEPTH);
  localparam logic [AW:0] CNT_ONE  = (AW+1)'(1);

  state_e           state_q, state_d;
  logic [AW:0]      count_q, count_d;
  logic [WIDTH-1:0] dout_q, dout_d;
  logic             ovf_q, ovf_d;
  logic             udf_q, udf_d;
  logic [WIDTH-1:0] swap_a_q, swap_a_d;
  logic [WIDTH-1:0] swap_b_q, swap_b_d;

  logic             ovf_set, udf_set;
  logic             wr_en;
  logic [AW-1:0]    wr_addr;
  logic [WIDTH-1:0] wr_data;
  logic [WIDTH-1:0] rd_top, rd_sub;
  logic [AW-1:0]    push_idx, top_idx, sub_idx;
  logic             full_w, empty_w, has2_w;
  op_e              op_w;

  // Index math is modulo DEPTH: when full, push_idx wraps to 0 but is never
  // written because the full guard blocks it.
  assign push_idx = count_q[AW-1:0];
  assign top_idx  = count_q[AW-1:0] - AW'(1);
  assign sub_idx  = count_q[AW-1:0] - AW'(2);

  assign full_w  = (count_q == CNT_FULL);
  assign empty_w = (count_q == '0);
  assign has2_w  = (count_q > CNT_ONE);

  stack_ram #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_ram (
    .clk       (clk),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .rd_addr_a (top_idx),
    .rd_data_a (rd_top),
    .rd_addr_b (sub_idx),
    .rd_data_b (rd_sub)
  );

  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    dout_d   = dout_q;
    swap_a_d = swap_a_q;
    swap_b_d = swap_b_q;
    wr_en    = 1'b0;
    wr_addr  = top_idx;
    wr_data  = din;
    ovf_set  = 1'b0;
    udf_set  = 1'b0;
    op_w     = op_e'(op);

    unique case (state_q)
      ST_IDLE: begin
        if (op_valid) begin
          case (op_w)
            OP_PUSH: begin
              if (!full_w) begin
                wr_en   = 1'b1;
                wr_addr = push_idx;
                wr_data = din;
                count_d = count_q + CNT_ONE;
                dout_d  = din;
              end else begin
                ovf_set = 1'b1;
              end
            end
            OP_POP: begin
              if (!empty_w) begin
                count_d = count_q - CNT_ONE;
                dout_d  = has2_w ? rd_sub : '0;
              end else begin
                udf_set = 1'b1;
              end
            end
            OP_DUP: begin
              if (empty_w) begin
                udf_set = 1'b1;
              end else if (full_w) begin
                ovf_set = 1'b1;
              end else begin
                wr_en   = 1'b1;
                wr_addr = push_idx;
                wr_data = rd_top;
                count_d = count_q + CNT_ONE;
              end
            end
            OP_SWAP: begin
              if (has2_w) begin
                // First half: old second-from-top moves up; old top is
                // written down on the next cycle from the latch.
                swap_a_d = rd_top;
                swap_b_d = rd_sub;
                wr_en    = 1'b1;
                wr_addr  = top_idx;
                wr_data  = rd_sub;
                state_d  = ST_SWAP2;
              end else begin
                udf_set = 1'b1;
              end
            end
            OP_REPLACE: begin
              if (!empty_w) begin
                wr_en   = 1'b1;
                wr_addr = top_idx;
                wr_data = din;
                dout_d  = din;
              end else begin
                udf_set = 1'b1;
              end
            end
            OP_CLEAR: begin
              count_d = '0;
              dout_d  = '0;
            end
            default: ;
          endcase
        end
      end
      ST_SWAP2: begin
        wr_en   = 1'b1;
        wr_addr = sub_idx;
        wr_data = swap_a_q;
        dout_d  = swap_b_q;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    // Set has priority over clear.
    ovf_d = ovf_set | (ovf_q & ~err_clr);
    udf_d = udf_set | (udf_q & ~err_clr);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      count_q <= '0;
      dout_q  <= '0;
      ovf_q   <= 1'b0;
      udf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      dout_q  <= dout_d;
      ovf_q   <= ovf_d;
      udf_q   <= udf_d;
    end
  end

  // SWAP operand latches are pure data and need no reset.
  always_ff @(posedge clk) begin
    swap_a_q <= swap_a_d;
    swap_b_q <= swap_b_d;
  end

  assign op_ready  = (state_q == ST_IDLE);
  assign dout      = dout_q;
  assign count     = count_q;
  assign empty     = empty_w;
  assign full      = full_w;
  assign overflow  = ovf_q;
  assign underflow = udf_q;

endmodule

// File: tb/tb_stack_engine.sv
// Directed bench for stack_engine with DEPTH=4, WIDTH=16.
module tb_stack_engine;
  import stack_engine_pkg::*;

  localparam int WIDTH = 16;
  localparam int DEPTH = 4;

  logic             clk;
  logic             reset;
  logic             op_valid;
  logic [2:0]       op;
  logic             op_ready;
  logic [WIDTH-1:0] din;
  logic [WIDTH-1:0] dout;
  logic [2:0]       count;
  logic             empty;
  logic             full;
  logic             overflow;
  logic             underflow;
  logic             err_clr;

  int checks   = 0;
  int failures = 0;

  stack_engine #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .op_valid  (op_valid),
    .op        (op),
    .op_ready  (op_ready),
    .din       (din),
    .dout      (dout),
    .count     (count),
    .empty     (empty),
    .full      (full),
    .overflow  (overflow),
    .underflow (underflow),
    .err_clr   (err_clr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
      $error("check %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Present one op for exactly one edge, then sample 1 time unit later.
  task automatic do_op(input logic [2:0] o, input logic [WIDTH-1:0] d, input logic clr);
    @(negedge clk);
    op_valid = 1'b1;
    op       = o;
    din      = d;
    err_clr  = clr;
    @(posedge clk);
    #1;
    op_valid = 1'b0;
    op       = OP_NOP;
    din      = '0;
    err_clr  = 1'b0;
  endtask

  task automatic clr_only();
    @(negedge clk);
    err_clr = 1'b1;
    @(posedge clk);
    #1;
    err_clr = 1'b0;
  endtask

  initial begin
    reset    = 1'b0;
    op_valid = 1'b0;
    op       = OP_NOP;
    din      = '0;
    err_clr  = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_dout", 32'(dout), 32'h0);
    chk("rst_empty", 32'(empty), 32'd1);
    chk("rst_full", 32'(full), 32'd0);
    chk("rst_ovf", 32'(overflow), 32'd0);
    chk("rst_udf", 32'(underflow), 32'd0);
    chk("rst_ready", 32'(op_ready), 32'd1);
    @(negedge clk);
    reset = 1'b1;

    // Fill the stack
    do_op(OP_PUSH, 16'h1111, 1'b0);
    chk("push1_count", 32'(count), 32'd1);
    chk("push1_dout", 32'(dout), 32'h1111);
    chk("push1_empty", 32'(empty), 32'd0);
    do_op(OP_PUSH, 16'h2222, 1'b0);
    chk("push2_count", 32'(count), 32'd2);
    chk("push2_dout", 32'(dout), 32'h2222);
    do_op(OP_PUSH, 16'h3333, 1'b0);
    chk("push3_count", 32'(count), 32'd3);
    chk("push3_dout", 32'(dout), 32'h3333);
    chk("push3_full", 32'(full), 32'd0);
    do_op(OP_PUSH, 16'h4444, 1'b0);
    chk("push4_count", 32'(count), 32'd4);
    chk("push4_dout", 32'(dout), 32'h4444);
    chk("push4_full", 32'(full), 32'd1);

    // Overflow
    do_op(OP_PUSH, 16'h5555, 1'b0);
    chk("ovf_count", 32'(count), 32'd4);
    chk("ovf_dout", 32'(dout), 32'h4444);
    chk("ovf_flag", 32'(overflow), 32'd1);
    chk("ovf_udf", 32'(underflow), 32'd0);
    clr_only();
    chk("ovf_clr", 32'(overflow), 32'd0);

    // Pop down through the full stack
    do_op(OP_POP, 16'h0, 1'b0);
    chk("pop_full_count", 32'(count), 32'd3);
    chk("pop_full_dout", 32'(dout), 32'h3333);

    // Op 7 and op_valid=0 leave state alone
    do_op(OP_NOP7, 16'h9999, 1'b0);
    chk("nop7_count", 32'(count), 32'd3);
    chk("nop7_dout", 32'(dout), 32'h3333);

    // SWAP on [0x1111,0x2222]
    do_op(OP_CLEAR, 16'h0, 1'b0);
    do_op(OP_PUSH, 16'h1111, 1'b0);
    do_op(OP_PUSH, 16'h2222, 1'b0);
    do_op(OP_SWAP, 16'h0, 1'b0);
    chk("swap_busy", 32'(op_ready), 32'd0);
    @(posedge clk);
    #1;
    chk("swap_ready", 32'(op_ready), 32'd1);
    chk("swap_dout", 32'(dout), 32'h1111);
    chk("swap_count", 32'(count), 32'd2);
    do_op(OP_POP, 16'h0, 1'b0);
    chk("swap_pop_dout", 32'(dout), 32'h2222);
    chk("swap_pop_count", 32'(count), 32'd1);
    do_op(OP_POP, 16'h0, 1'b0);
    chk("pop_last_dout", 32'(dout), 32'h0);
    chk("pop_last_empty", 32'(empty), 32'd1);

    // Underflow on empty stack, one op at a time
    do_op(OP_POP, 16'h0, 1'b0);
    chk("udf_pop", 32'(underflow), 32'd1);
    chk("udf_pop_count", 32'(count), 32'd0);
    clr_only();
    chk("udf_clr1", 32'(underflow), 32'd0);
    do_op(OP_SWAP, 16'h0, 1'b0);
    chk("udf_swap", 32'(underflow), 32'd1);
    chk("udf_swap_ready", 32'(op_ready), 32'd1);
    clr_only();
    chk("udf_clr2", 32'(underflow), 32'd0);
    do_op(OP_DUP, 16'h0, 1'b0);
    chk("udf_dup", 32'(underflow), 32'd1);
    chk("udf_dup_ovf", 32'(overflow), 32'd0);
    clr_only();
    do_op(OP_REPLACE, 16'h1234, 1'b0);
    chk("udf_repl", 32'(underflow), 32'd1);
    chk("udf_repl_count", 32'(count), 32'd0);
    chk("udf_repl_dout", 32'(dout), 32'h0);
    do_op(OP_POP, 16'h0, 1'b1);
    chk("udf_set_wins", 32'(underflow), 32'd1);

    // DUP / REPLACE / POP / CLEAR
    clr_only();
    do_op(OP_PUSH, 16'h00AA, 1'b0);
    do_op(OP_DUP, 16'h0, 1'b0);
    chk("dup_count", 32'(count), 32'd2);
    chk("dup_dout", 32'(dout), 32'h00AA);
    do_op(OP_REPLACE, 16'hBEEF, 1'b0);
    chk("repl_dout", 32'(dout), 32'hBEEF);
    chk("repl_count", 32'(count), 32'd2);
    do_op(OP_POP, 16'h0, 1'b0);
    chk("dup_pop_dout", 32'(dout), 32'h00AA);
    chk("dup_pop_count", 32'(count), 32'd1);
    do_op(OP_CLEAR, 16'h0, 1'b0);
    chk("clear_count", 32'(count), 32'd0);
    chk("clear_empty", 32'(empty), 32'd1);
    chk("clear_dout", 32'(dout), 32'h0);
    chk("clear_udf", 32'(underflow), 32'd0);

    // DUP while full -> overflow
    do_op(OP_PUSH, 16'h0001, 1'b0);
    do_op(OP_DUP, 16'h0, 1'b0);
    do_op(OP_DUP, 16'h0, 1'b0);
    do_op(OP_DUP, 16'h0, 1'b0);
    chk("dup_fill_full", 32'(full), 32'd1);
    do_op(OP_DUP, 16'h0, 1'b0);
    chk("dup_ovf", 32'(overflow), 32'd1);
    chk("dup_ovf_count", 32'(count), 32'd4);
    do_op(OP_CLEAR, 16'h0, 1'b0);
    chk("clear_keeps_ovf", 32'(overflow), 32'd1);
    clr_only();

    // Reset during the second SWAP cycle
    do_op(OP_PUSH, 16'h0001, 1'b0);
    do_op(OP_PUSH, 16'h0002, 1'b0);
    do_op(OP_SWAP, 16'h0, 1'b0);
    chk("rswap_busy", 32'(op_ready), 32'd0);
    reset = 1'b0;
    #1;
    chk("rswap_count", 32'(count), 32'd0);
    chk("rswap_dout", 32'(dout), 32'h0);
    chk("rswap_ready", 32'(op_ready), 32'd1);
    @(negedge clk);
    reset = 1'b1;
    do_op(OP_PUSH, 16'h0007, 1'b0);
    chk("rswap_push_dout", 32'(dout), 32'h0007);
    chk("rswap_push_count", 32'(count), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
